// File: rtl/inverse_seq_if.sv
// Handshake bundle between the inversion sequencer and its row-op datapath.
// The master side drives start/pivot_zero/alu_done; the sequencer is the slave.
interface inverse_seq_if;
   logic       start;
   logic       pivot_zero;
   logic       alu_done;
   logic       op_valid;
   logic [1:0] op;
   logic [2:0] piv;
   logic [2:0] row;
   logic       busy;
   logic       done;
   logic       singular;
   logic [5:0] op_count;

   modport master (
      output start, pivot_zero, alu_done,
      input  op_valid, op, piv, row, busy, done, singular, op_count
   );

   modport slave (
      input  start, pivot_zero, alu_done,
      output op_valid, op, piv, row, busy, done, singular, op_count
   );
endinterface

// File: rtl/inverse_seq.sv
// Gauss-Jordan sequencer: for each pivot k, check the pivot, normalise row k,
// then eliminate column k from every other row; all outputs are registered.
module inverse_seq #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   inverse_seq_if.slave bus
);
   localparam logic [2:0] K_LAST  = 3'(N - 1);
   localparam logic [3:0] ROW_END = 4'(N);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_NORM, S_ELIM, S_FIN} state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_k, w_k_nxt;

   logic       r_op_valid, w_op_valid;
   logic [1:0] r_op, w_op;
   logic [2:0] r_piv, w_piv;
   logic [2:0] r_row, w_row;
   logic       r_busy, w_busy;
   logic       r_done, w_done;
   logic       r_singular, w_singular;
   logic [5:0] r_op_count, w_op_count;

   logic       w_fire;
   logic       w_accept;
   logic [3:0] w_row_inc;
   logic [3:0] w_row_skip;
   logic       w_last_elim;

   assign w_fire     = r_op_valid & bus.alu_done;
   assign w_accept   = (r_state == S_IDLE) & bus.start;
   // Next elimination row skips the pivot row; running past N-1 ends the pivot.
   assign w_row_inc  = {1'b0, r_row} + 4'd1;
   assign w_row_skip = (w_row_inc == {1'b0, r_k}) ? (w_row_inc + 4'd1) : w_row_inc;
   assign w_last_elim = (w_row_skip >= ROW_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_k        <= 3'd0;
         r_op_valid <= 1'b0;
         r_op       <= 2'b00;
         r_piv      <= 3'd0;
         r_row      <= 3'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_singular <= 1'b0;
         r_op_count <= 6'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_k        <= w_k_nxt;
         r_op_valid <= w_op_valid;
         r_op       <= w_op;
         r_piv      <= w_piv;
         r_row      <= w_row;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_singular <= w_singular;
         r_op_count <= w_op_count;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_CHECK;
               w_k_nxt     = 3'd0;
            end
         end
         S_CHECK: w_state_nxt = bus.pivot_zero ? S_FIN : S_NORM;
         S_NORM: begin
            if (w_fire) w_state_nxt = S_ELIM;
         end
         S_ELIM: begin
            if (w_fire && w_last_elim) begin
               if (r_k == K_LAST) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_CHECK;
                  w_k_nxt     = r_k + 3'd1;
               end
            end
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Register inputs are derived from the next state so outputs line up with it.
   always_comb begin
      w_op_valid = (w_state_nxt == S_NORM) || (w_state_nxt == S_ELIM);
      w_op       = (w_state_nxt == S_NORM) ? 2'b01 :
                   (w_state_nxt == S_ELIM) ? 2'b10 : 2'b00;
      w_piv      = w_k_nxt;
      w_busy     = (w_state_nxt == S_CHECK) || (w_state_nxt == S_NORM) ||
                   (w_state_nxt == S_ELIM);
      w_done     = (w_state_nxt == S_FIN);

      w_row = r_row;
      if (w_accept) begin
         w_row = 3'd0;
      end else if (w_state_nxt == S_NORM) begin
         w_row = w_k_nxt;
      end else if ((w_state_nxt == S_ELIM) && (r_state == S_NORM)) begin
         w_row = (r_k == 3'd0) ? 3'd1 : 3'd0;
      end else if ((r_state == S_ELIM) && w_fire && !w_last_elim) begin
         w_row = w_row_skip[2:0];
      end

      w_singular = r_singular;
      if (w_accept) begin
         w_singular = 1'b0;
      end else if ((r_state == S_CHECK) && bus.pivot_zero) begin
         w_singular = 1'b1;
      end

      w_op_count = r_op_count;
      if (w_accept) begin
         w_op_count = 6'd0;
      end else if (w_fire && (r_op_count != 6'd63)) begin
         w_op_count = r_op_count + 6'd1;
      end
   end

   assign bus.op_valid = r_op_valid;
   assign bus.op       = r_op;
   assign bus.piv      = r_piv;
   assign bus.row      = r_row;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.singular = r_singular;
   assign bus.op_count = r_op_count;
endmodule
